// File: rtl/int_priority_arbiter.sv
// Three-source nested interrupt arbiter with EPC stack; take/return outputs are registered, one cycle after the deciding edge.
// No backpressure: req is a level held by the source until the one-hot clr pulse acknowledges it.
module int_priority_arbiter #(
  parameter logic [31:0] VectorBase  = 32'h0000_0800,
  parameter int unsigned NrOfSources = 3
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [NrOfSources-1:0] req,
  input  logic [NrOfSources-1:0] mask,
  input  logic                   ie,
  input  logic                   instr_done,
  input  logic                   eret,
  input  logic [31:0]            pc_next,
  output logic                   int_take,
  output logic [31:0]            vector,
  output logic [NrOfSources-1:0] clr,
  output logic                   int_ret,
  output logic [31:0]            epc,
  output logic [NrOfSources-1:0] in_service,
  output logic [1:0]             depth,
  output logic                   eret_err
);

  typedef enum logic {
    RUN   = 1'b0,
    ENTER = 1'b1
  } state_e;

  state_e                 state_q;
  state_e                 state_d;
  logic [1:0]             cur_prio;
  logic [NrOfSources-1:0] pend;
  logic [NrOfSources-1:0] eligible;
  logic [NrOfSources-1:0] top_service;
  logic [NrOfSources-1:0] win_onehot;
  logic [1:0]             win_idx;
  logic                   take;
  logic                   ret_ok;
  logic                   ret_err;
  logic [31:0]            stack_q [3];

  // Source i may preempt only when its level (i+1) exceeds the running priority.
  always_comb begin
    cur_prio    = 2'd0;
    top_service = '0;
    if (in_service[2]) begin
      cur_prio    = 2'd3;
      top_service = 3'b100;
    end else if (in_service[1]) begin
      cur_prio    = 2'd2;
      top_service = 3'b010;
    end else if (in_service[0]) begin
      cur_prio    = 2'd1;
      top_service = 3'b001;
    end

    pend        = req & mask & ~in_service;
    eligible[0] = pend[0] & (cur_prio == 2'd0);
    eligible[1] = pend[1] & (cur_prio <= 2'd1);
    eligible[2] = pend[2] & (cur_prio <= 2'd2);

    win_idx    = 2'd0;
    win_onehot = 3'b001;
    if (eligible[2]) begin
      win_idx    = 2'd2;
      win_onehot = 3'b100;
    end else if (eligible[1]) begin
      win_idx    = 2'd1;
      win_onehot = 3'b010;
    end
  end

  // eret has precedence over a take; both are only considered in RUN.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    ret_ok  = 1'b0;
    ret_err = 1'b0;
    case (state_q)
      RUN: begin
        if (eret) begin
          ret_ok  = (depth != 2'd0);
          ret_err = (depth == 2'd0);
        end else if (ie && instr_done && (|eligible)) begin
          take    = 1'b1;
          state_d = ENTER;
        end
      end
      ENTER: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      int_take   <= 1'b0;
      clr        <= '0;
      vector     <= '0;
      int_ret    <= 1'b0;
      epc        <= '0;
      in_service <= '0;
      depth      <= 2'd0;
      eret_err   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      int_take <= take;
      clr      <= take ? win_onehot : '0;
      vector   <= take ? (VectorBase + {26'd0, win_idx, 4'd0}) : '0;
      int_ret  <= ret_ok;
      epc      <= ret_ok ? stack_q[depth - 2'd1] : '0;

      if (take) begin
        stack_q[depth] <= pc_next;
        depth          <= depth + 2'd1;
        in_service     <= in_service | win_onehot;
      end else if (ret_ok) begin
        depth      <= depth - 2'd1;
        in_service <= in_service & ~top_service;
      end

      if (ret_err) begin
        eret_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_int_priority_arbiter.sv
// Directed bench for int_priority_arbiter: take, priority, nesting, blocking, underflow, collision, reset.
module tb_int_priority_arbiter;

  logic        Clock;
  logic        Reset;
  logic [2:0]  req;
  logic [2:0]  mask;
  logic        ie;
  logic        instr_done;
  logic        eret;
  logic [31:0] pc_next;
  logic        int_take;
  logic [31:0] vector;
  logic [2:0]  clr;
  logic        int_ret;
  logic [31:0] epc;
  logic [2:0]  in_service;
  logic [1:0]  depth;
  logic        eret_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  int_priority_arbiter #(
    .VectorBase (32'h0000_0800),
    .NrOfSources(3)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .req       (req),
    .mask      (mask),
    .ie        (ie),
    .instr_done(instr_done),
    .eret      (eret),
    .pc_next   (pc_next),
    .int_take  (int_take),
    .vector    (vector),
    .clr       (clr),
    .int_ret   (int_ret),
    .epc       (epc),
    .in_service(in_service),
    .depth     (depth),
    .eret_err  (eret_err)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; req = '0; mask = 3'b111; ie = 1'b1; instr_done = 1'b1; eret = 1'b0; pc_next = '0;
    tick();
    tick();
    vec_cnt++;
    if ({int_take, clr, vector, int_ret, epc, in_service, depth, eret_err} !== 75'd0) begin
      err_cnt++;
      $display("FAIL reset_state got %h exp 0", {int_take, clr, vector, int_ret, epc, in_service, depth, eret_err});
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req = 3'b001; pc_next = 32'h100;
    tick();
    vec_cnt++;
    if ({int_take, clr, vector, in_service, depth} !== {1'b1, 3'b001, 32'h800, 3'b001, 2'd1}) begin
      err_cnt++;
      $display("FAIL single_take got %h exp %h", {int_take, clr, vector, in_service, depth}, {1'b1, 3'b001, 32'h800, 3'b001, 2'd1});
    end
    req = 3'b000;
    tick();
    vec_cnt++;
    if ({int_take, clr, vector} !== 36'd0) begin
      err_cnt++;
      $display("FAIL single_enter_len got %h exp 0", {int_take, clr, vector});
    end
    eret = 1'b1;
    tick();
    vec_cnt++;
    if ({int_ret, epc, depth, in_service} !== {1'b1, 32'h100, 2'd0, 3'b000}) begin
      err_cnt++;
      $display("FAIL single_eret got %h exp %h", {int_ret, epc, depth, in_service}, {1'b1, 32'h100, 2'd0, 3'b000});
    end
    eret = 1'b0;
    tick();
    vec_cnt++;
    if ({int_ret, epc} !== 33'd0) begin
      err_cnt++;
      $display("FAIL single_ret_pulse got %h exp 0", {int_ret, epc});
    end
  endtask

  task automatic test_simultaneous();
    req = 3'b101; pc_next = 32'h10;
    tick();
    vec_cnt++;
    if ({int_take, clr, vector, in_service} !== {1'b1, 3'b100, 32'h820, 3'b100}) begin
      err_cnt++;
      $display("FAIL simul_first got %h exp %h", {int_take, clr, vector, in_service}, {1'b1, 3'b100, 32'h820, 3'b100});
    end
    req = 3'b001;
    tick();
    tick();
    vec_cnt++;
    if ({int_take, clr, depth} !== {1'b0, 3'b000, 2'd1}) begin
      err_cnt++;
      $display("FAIL simul_low_blocked got %h exp %h", {int_take, clr, depth}, {1'b0, 3'b000, 2'd1});
    end
    eret = 1'b1;
    tick();
    vec_cnt++;
    if ({int_ret, epc, int_take, depth} !== {1'b1, 32'h10, 1'b0, 2'd0}) begin
      err_cnt++;
      $display("FAIL simul_eret got %h exp %h", {int_ret, epc, int_take, depth}, {1'b1, 32'h10, 1'b0, 2'd0});
    end
    eret = 1'b0; pc_next = 32'h14;
    tick();
    vec_cnt++;
    if ({int_take, clr, vector} !== {1'b1, 3'b001, 32'h800}) begin
      err_cnt++;
      $display("FAIL simul_second got %h exp %h", {int_take, clr, vector}, {1'b1, 3'b001, 32'h800});
    end
    req = 3'b000;
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
  endtask

  task automatic test_nesting();
    req = 3'b001; pc_next = 32'h200;
    tick();
    req = 3'b000;
    tick();
    req = 3'b010; pc_next = 32'h300;
    tick();
    vec_cnt++;
    if ({int_take, clr, vector, in_service, depth} !== {1'b1, 3'b010, 32'h810, 3'b011, 2'd2}) begin
      err_cnt++;
      $display("FAIL nest_take got %h exp %h", {int_take, clr, vector, in_service, depth}, {1'b1, 3'b010, 32'h810, 3'b011, 2'd2});
    end
    req = 3'b000;
    tick();
    eret = 1'b1;
    tick();
    vec_cnt++;
    if ({int_ret, epc, in_service, depth} !== {1'b1, 32'h300, 3'b001, 2'd1}) begin
      err_cnt++;
      $display("FAIL nest_eret1 got %h exp %h", {int_ret, epc, in_service, depth}, {1'b1, 32'h300, 3'b001, 2'd1});
    end
    tick();
    vec_cnt++;
    if ({int_ret, epc, in_service, depth} !== {1'b1, 32'h200, 3'b000, 2'd0}) begin
      err_cnt++;
      $display("FAIL nest_eret2 got %h exp %h", {int_ret, epc, in_service, depth}, {1'b1, 32'h200, 3'b000, 2'd0});
    end
    eret = 1'b0;
    tick();
  endtask

  task automatic test_depth3();
    req = 3'b001; pc_next = 32'hA0;
    tick();
    req = 3'b010; pc_next = 32'hB0;
    tick();
    tick();
    req = 3'b100; pc_next = 32'hC0;
    tick();
    tick();
    req = 3'b111;
    tick();
    vec_cnt++;
    if ({int_take, clr, in_service, depth} !== {1'b0, 3'b000, 3'b111, 2'd3}) begin
      err_cnt++;
      $display("FAIL depth3_full got %h exp %h", {int_take, clr, in_service, depth}, {1'b0, 3'b000, 3'b111, 2'd3});
    end
    req = 3'b000; eret = 1'b1;
    tick();
    vec_cnt++;
    if ({int_ret, epc, in_service} !== {1'b1, 32'hC0, 3'b011}) begin
      err_cnt++;
      $display("FAIL depth3_pop1 got %h exp %h", {int_ret, epc, in_service}, {1'b1, 32'hC0, 3'b011});
    end
    tick();
    tick();
    vec_cnt++;
    if ({int_ret, epc, depth} !== {1'b1, 32'hA0, 2'd0}) begin
      err_cnt++;
      $display("FAIL depth3_pop3 got %h exp %h", {int_ret, epc, depth}, {1'b1, 32'hA0, 2'd0});
    end
    eret = 1'b0;
    tick();
  endtask

  task automatic test_blocked();
    req = 3'b111; ie = 1'b0;
    tick();
    vec_cnt++;
    if ({int_take, clr, depth} !== 6'd0) begin
      err_cnt++;
      $display("FAIL blk_ie got %h exp 0", {int_take, clr, depth});
    end
    ie = 1'b1; mask = 3'b000;
    tick();
    vec_cnt++;
    if ({int_take, clr, depth} !== 6'd0) begin
      err_cnt++;
      $display("FAIL blk_mask got %h exp 0", {int_take, clr, depth});
    end
    mask = 3'b111; instr_done = 1'b0;
    tick();
    vec_cnt++;
    if ({int_take, clr, depth} !== 6'd0) begin
      err_cnt++;
      $display("FAIL blk_instr_done got %h exp 0", {int_take, clr, depth});
    end
    instr_done = 1'b1; req = 3'b100; pc_next = 32'h400;
    tick();
    req = 3'b111;
    tick();
    tick();
    vec_cnt++;
    if ({int_take, clr, in_service, depth} !== {1'b0, 3'b000, 3'b100, 2'd1}) begin
      err_cnt++;
      $display("FAIL blk_prio got %h exp %h", {int_take, clr, in_service, depth}, {1'b0, 3'b000, 3'b100, 2'd1});
    end
    ie = 1'b0; mask = 3'b000;
    tick();
    vec_cnt++;
    if ({in_service, depth} !== {3'b100, 2'd1}) begin
      err_cnt++;
      $display("FAIL blk_mask_keeps got %h exp %h", {in_service, depth}, {3'b100, 2'd1});
    end
    ie = 1'b1; mask = 3'b111; req = 3'b000; eret = 1'b1;
    tick();
    vec_cnt++;
    if ({int_ret, epc} !== {1'b1, 32'h400}) begin
      err_cnt++;
      $display("FAIL blk_eret got %h exp %h", {int_ret, epc}, {1'b1, 32'h400});
    end
    eret = 1'b0;
    tick();
  endtask

  task automatic test_underflow_collision();
    eret = 1'b1;
    tick();
    vec_cnt++;
    if ({eret_err, depth, int_ret, epc, int_take} !== {1'b1, 2'd0, 1'b0, 32'd0, 1'b0}) begin
      err_cnt++;
      $display("FAIL underflow got %h exp %h", {eret_err, depth, int_ret, epc, int_take}, {1'b1, 2'd0, 1'b0, 32'd0, 1'b0});
    end
    eret = 1'b0; req = 3'b001; pc_next = 32'h40;
    tick();
    req = 3'b000;
    tick();
    req = 3'b010; eret = 1'b1;
    tick();
    vec_cnt++;
    if ({int_ret, epc, int_take, clr, depth} !== {1'b1, 32'h40, 1'b0, 3'b000, 2'd0}) begin
      err_cnt++;
      $display("FAIL collision got %h exp %h", {int_ret, epc, int_take, clr, depth}, {1'b1, 32'h40, 1'b0, 3'b000, 2'd0});
    end
    eret = 1'b0; pc_next = 32'h50;
    tick();
    vec_cnt++;
    if ({int_take, vector, depth, eret_err} !== {1'b1, 32'h810, 2'd1, 1'b1}) begin
      err_cnt++;
      $display("FAIL after_collision got %h exp %h", {int_take, vector, depth, eret_err}, {1'b1, 32'h810, 2'd1, 1'b1});
    end
    req = 3'b000;
    tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick();
  endtask

  task automatic test_reset_enter();
    req = 3'b100; pc_next = 32'h70;
    tick();
    vec_cnt++;
    if ({int_take, clr} !== {1'b1, 3'b100}) begin
      err_cnt++;
      $display("FAIL rst_pre_enter got %h exp %h", {int_take, clr}, {1'b1, 3'b100});
    end
    #2;
    Reset = 1'b1;
    #1;
    vec_cnt++;
    if ({int_take, clr, vector, int_ret, epc, in_service, depth, eret_err} !== 75'd0) begin
      err_cnt++;
      $display("FAIL rst_async got %h exp 0", {int_take, clr, vector, int_ret, epc, in_service, depth, eret_err});
    end
    req = 3'b000;
    tick();
    Reset = 1'b0;
    tick();
    tick();
    vec_cnt++;
    if ({int_take, clr, depth, in_service} !== 9'd0) begin
      err_cnt++;
      $display("FAIL rst_no_clr got %h exp 0", {int_take, clr, depth, in_service});
    end
    req = 3'b001; pc_next = 32'h60;
    tick();
    vec_cnt++;
    if ({int_take, clr, vector, depth} !== {1'b1, 3'b001, 32'h800, 2'd1}) begin
      err_cnt++;
      $display("FAIL rst_first_take got %h exp %h", {int_take, clr, vector, depth}, {1'b1, 3'b001, 32'h800, 2'd1});
    end
    req = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_nesting();
    test_depth3();
    test_blocked();
    test_underflow_collision();
    test_reset_enter();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/int_priority_arbiter.md
INT_PRIORITY_ARBITER -- requirements
Module: int_priority_arbiter

Interface
REQ-001 The block SHALL take parameter VectorBase, default 32'h0000_0800, as the base address of the interrupt handler vectors.
REQ-002 The block SHALL take parameter NrOfSources, default 3, fixed at 3 for this release.
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 3 bits: level request from the three request registers; bit 2 has the highest priority and bit 0 the lowest.
REQ-006 The block SHALL have port mask, input, 3 bits: per-source enable, where 1 means enabled.
REQ-007 The block SHALL have port ie, input, 1 bit: global interrupt enable.
REQ-008 The block SHALL have port instr_done, input, 1 bit: marks the instruction-boundary cycle.
REQ-009 The block SHALL have port eret, input, 1 bit: return-from-handler strobe.
REQ-010 The block SHALL have port pc_next, input, 32 bits: return address to save.
REQ-011 The block SHALL have port int_take, output, 1 bit: one-cycle redirect pulse.
REQ-012 The block SHALL have port vector, output, 32 bits: handler address, valid while int_take=1.
REQ-013 The block SHALL have port clr, output, 3 bits: one-hot, one-cycle clear to the serviced request register.
REQ-014 The block SHALL have port int_ret, output, 1 bit: one-cycle return pulse.
REQ-015 The block SHALL have port epc, output, 32 bits: return address, valid while int_ret=1.
REQ-016 The block SHALL have port in_service, output, 3 bits: sources currently being serviced.
REQ-017 The block SHALL have port depth, output, 2 bits: nesting depth, 0 to 3.
REQ-018 The block SHALL have port eret_err, output, 1 bit: sticky flag for an underflow eret.

Function
REQ-019 The FSM SHALL have the states RUN and ENTER; ENTER SHALL last exactly one cycle and then return to RUN.
REQ-020 The block SHALL compute cur_prio as the index of the highest in_service bit plus 1, and 0 when in_service is 0.
REQ-021 The block SHALL treat a source i as eligible when req[i] & mask[i] & ~in_service[i] holds and i+1 > cur_prio.
REQ-022 The block SHALL take an interrupt in a cycle where the state is RUN, ie=1, instr_done=1, eret=0, and at least one source is eligible; the highest eligible index k wins.
REQ-023 On a take, at the next edge the block SHALL: push pc_next onto the 3-entry EPC stack at position depth; increment depth; set in_service[k]; and move to ENTER.
REQ-024 During ENTER, the block SHALL drive int_take=1, clr=1<<k, and vector=VectorBase+(k<<4), with all three registered; outside ENTER it SHALL drive int_take=0, clr=0, and vector=0.
REQ-025 The block SHALL NOT evaluate a take during ENTER; a request that persists SHALL be evaluated in the following RUN cycle.
REQ-026 On eret=1 in RUN with depth>0, at the next edge the block SHALL: decrement depth; clear the highest set in_service bit; register epc with stack[depth-1]; and pulse int_ret=1 for one cycle.
REQ-027 An eret in the same cycle as a take condition SHALL win; the take SHALL NOT occur in that cycle.
REQ-028 An eret while depth=0 SHALL leave all state unchanged and SHALL set eret_err=1 until Reset.
REQ-029 An eret during ENTER SHALL be ignored.
REQ-030 When int_ret=0, the block SHALL drive epc=0.
REQ-031 A take SHALL NOT occur at depth=3; this SHALL be consistent with REQ-021, since all three sources are then in service.
REQ-032 The block SHALL use mask and ie only for new takes; clearing either SHALL NOT alter in_service or the stack.
REQ-033 req is assumed synchronous to Clock; the block SHALL NOT synchronize it.

Reset
REQ-034 While Reset=1, regardless of Clock, the block SHALL hold: state=RUN, depth=0, in_service=0, stack entries=0, int_take=0, clr=0, vector=0, int_ret=0, epc=0, eret_err=0.
REQ-035 Reset during ENTER or mid-nesting SHALL discard all pending state; no clr pulse SHALL be emitted after Reset deasserts.
REQ-036 The first take after Reset deasserts SHALL be possible on the first rising edge at which REQ-022 holds.

Verification
REQ-037 The bench SHALL cover a single source: req=001, mask=111, ie=1, instr_done=1, pc_next=0x100 -> next cycle int_take=1, clr=001, vector=0x800, in_service=001, depth=1; then eret -> int_ret=1, epc=0x100, depth=0.
REQ-038 The bench SHALL cover simultaneous requests: req=101 -> source 2 is taken first (vector=0x820, clr=100); source 0 is not taken until after the eret, then vector=0x800.
REQ-039 The bench SHALL cover nesting: source 0 in service with pc 0x200, then req=010 with pc_next=0x300 -> take k=1, depth=2; eret -> epc=0x300; eret -> epc=0x200, depth=0.
REQ-040 The bench SHALL cover the blocked cases: ie=0, mask bit clear, instr_done=0, or an equal/lower priority than cur_prio -> int_take stays 0 and clr stays 0.
REQ-041 The bench SHALL cover underflow and collision: eret at depth=0 -> eret_err=1, depth=0, int_ret=0; eret and a take condition in the same cycle -> int_ret=1, int_take=0 in that next cycle.
REQ-042 The bench SHALL cover Reset asserted during ENTER: all outputs go to 0 immediately, and clr=000 thereafter until a new take.
